// File: rtl/fp_add_pipe.sv
// fp_add_pipe: four-stage IEEE-754 adder/subtractor with valid/ready
// handshakes, round-to-nearest-even, denormal flush and status flags.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, in_a, in_b,
//   in_sub (1 = A-B); out_valid/out_ready, out_sum,
//   out_flags = {invalid, overflow, underflow, inexact}.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic                   in_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_sum,
   output logic [3:0]             out_flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 4;
   localparam int EW = EXP_W + 2;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0] QNAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic w_en;

   // S1: unpack, classify, swap so |large| >= |small|
   logic             w_sa, w_sb, w_za, w_zb;
   logic             w_ia, w_ib, w_na, w_nb, w_swap;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_ma, w_mb;
   logic [W-2:0]     w_ka, w_kb;
   logic             w_sp;
   logic [W-1:0]     w_spv;
   logic [3:0]       w_spf;

   logic             r1_v, r1_sl, r1_ss, r1_sp;
   logic [EXP_W-1:0] r1_el, r1_es;
   logic [MAN_W:0]   r1_ml, r1_ms;
   logic [W-1:0]     r1_spv;
   logic [3:0]       r1_spf;

   always_comb begin
      w_sa = in_a[W-1];
      w_sb = in_b[W-1] ^ in_sub;
      w_ea = in_a[W-2:MAN_W];
      w_eb = in_b[W-2:MAN_W];
      w_ma = in_a[MAN_W-1:0];
      w_mb = in_b[MAN_W-1:0];
      w_za = (w_ea == '0);
      w_zb = (w_eb == '0);
      w_ia = (w_ea == EMAX) && (w_ma == '0);
      w_ib = (w_eb == EMAX) && (w_mb == '0);
      w_na = (w_ea == EMAX) && (w_ma != '0);
      w_nb = (w_eb == EMAX) && (w_mb != '0);
      // denormals compare as zero magnitude
      w_ka = w_za ? '0 : {w_ea, w_ma};
      w_kb = w_zb ? '0 : {w_eb, w_mb};
      w_swap = (w_kb > w_ka);
      w_sp  = 1'b1;
      w_spv = '0;
      w_spf = '0;
      if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sb))) begin
         w_spv = QNAN;
         w_spf = 4'b1000;
      end else if (w_ia) begin
         w_spv = {w_sa, EMAX, {MAN_W{1'b0}}};
      end else if (w_ib) begin
         w_spv = {w_sb, EMAX, {MAN_W{1'b0}}};
      end else if (w_za && w_zb) begin
         w_spv = {w_sa & w_sb, {(W-1){1'b0}}};
      end else if (w_za) begin
         w_spv = {w_sb, w_eb, w_mb};
      end else if (w_zb) begin
         w_spv = {w_sa, w_ea, w_ma};
      end else begin
         w_sp = 1'b0;
      end
   end

   // S2: align smaller significand, collect sticky
   logic [EXP_W-1:0] w_diff;
   logic [SW-1:0]    w_ext, w_al;
   logic [2*SW-1:0]  w_wide;

   logic             r2_v, r2_s, r2_sub, r2_sp;
   logic [EXP_W-1:0] r2_e;
   logic [SW-1:0]    r2_a, r2_b;
   logic [W-1:0]     r2_spv;
   logic [3:0]       r2_spf;

   always_comb begin
      w_diff = r1_el - r1_es;
      w_ext  = {r1_ms, 3'b000};
      w_wide = {w_ext, {SW{1'b0}}} >> w_diff;
      if (int'(w_diff) >= SW)
         w_al = {{(SW-1){1'b0}}, |r1_ms};
      else
         w_al = {w_wide[2*SW-1:SW+1],
                 w_wide[SW] | (|w_wide[SW-1:0])};
   end

   // S3: add or subtract magnitudes (never negative after swap)
   logic [SW:0]      w_sum;

   logic             r3_v, r3_s, r3_sp;
   logic [EXP_W-1:0] r3_e;
   logic [SW:0]      r3_sum;
   logic [W-1:0]     r3_spv;
   logic [3:0]       r3_spf;

   always_comb begin
      if (r2_sub)
         w_sum = {1'b0, r2_a} - {1'b0, r2_b};
      else
         w_sum = {1'b0, r2_a} + {1'b0, r2_b};
   end

   // S4: normalise, round to nearest even, pack
   int               w_lz;
   logic [SW-1:0]    w_n;
   logic [EW-1:0]    w_en_e, w_er;
   logic [MAN_W+1:0] w_mr;
   logic             w_g, w_r, w_s, w_up;
   logic [W-1:0]     w_res;
   logic [3:0]       w_flg;

   logic             r4_v;
   logic [W-1:0]     r4_sum;
   logic [3:0]       r4_flags;

   always_comb begin
      w_lz = SW;
      for (int i = 0; i < SW; i++)
         if (r3_sum[i]) w_lz = SW - 1 - i;
      if (r3_sum[SW]) begin
         w_n    = {r3_sum[SW:2], r3_sum[1] | r3_sum[0]};
         w_en_e = {2'b00, r3_e} + EW'(1);
      end else begin
         w_n    = r3_sum[SW-1:0] << w_lz;
         w_en_e = {2'b00, r3_e} - EW'(w_lz);
      end
      w_g  = w_n[2];
      w_r  = w_n[1];
      w_s  = w_n[0];
      w_up = w_g & (w_r | w_s | w_n[3]);
      w_mr = {1'b0, w_n[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
      w_er = w_en_e + {{(EW-1){1'b0}}, w_mr[MAN_W+1]};
      w_res = '0;
      w_flg = '0;
      if (r3_sp) begin
         w_res = r3_spv;
         w_flg = r3_spf;
      end else if (r3_sum == '0) begin
         w_res = '0;
      end else if (w_en_e[EW-1] || (w_en_e == '0)) begin
         w_res = {r3_s, {(W-1){1'b0}}};
         w_flg = 4'b0011;
      end else if (w_er >= {2'b00, EMAX}) begin
         w_res = {r3_s, EMAX, {MAN_W{1'b0}}};
         w_flg = 4'b0101;
      end else begin
         w_res = {r3_s, w_er[EXP_W-1:0], w_mr[MAN_W-1:0]};
         w_flg = {3'b000, w_g | w_r | w_s};
      end
   end

   // one enable freezes every stage, bubbles included
   assign w_en      = !(r4_v && !out_ready);
   assign in_ready  = w_en;
   assign out_valid = r4_v;
   assign out_sum   = r4_sum;
   assign out_flags = r4_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_v <= 1'b0; r1_sl <= 1'b0; r1_ss <= 1'b0;
         r1_sp <= 1'b0; r1_el <= '0; r1_es <= '0;
         r1_ml <= '0; r1_ms <= '0; r1_spv <= '0;
         r1_spf <= '0;
         r2_v <= 1'b0; r2_s <= 1'b0; r2_sub <= 1'b0;
         r2_sp <= 1'b0; r2_e <= '0; r2_a <= '0;
         r2_b <= '0; r2_spv <= '0; r2_spf <= '0;
         r3_v <= 1'b0; r3_s <= 1'b0; r3_sp <= 1'b0;
         r3_e <= '0; r3_sum <= '0; r3_spv <= '0;
         r3_spf <= '0;
         r4_v <= 1'b0; r4_sum <= '0; r4_flags <= '0;
      end else if (w_en) begin
         r1_v   <= in_valid;
         r1_sl  <= w_swap ? w_sb : w_sa;
         r1_ss  <= w_swap ? w_sa : w_sb;
         r1_el  <= w_swap ? w_eb : w_ea;
         r1_es  <= w_swap ? w_ea : w_eb;
         r1_ml  <= w_swap ? {1'b1, w_mb} : {1'b1, w_ma};
         r1_ms  <= w_swap ? {1'b1, w_ma} : {1'b1, w_mb};
         r1_sp  <= w_sp;
         r1_spv <= w_spv;
         r1_spf <= w_spf;
         r2_v   <= r1_v;
         r2_s   <= r1_sl;
         r2_sub <= r1_sl ^ r1_ss;
         r2_e   <= r1_el;
         r2_a   <= {r1_ml, 3'b000};
         r2_b   <= w_al;
         r2_sp  <= r1_sp;
         r2_spv <= r1_spv;
         r2_spf <= r1_spf;
         r3_v   <= r2_v;
         r3_s   <= r2_s;
         r3_e   <= r2_e;
         r3_sum <= w_sum;
         r3_sp  <= r2_sp;
         r3_spv <= r2_spv;
         r3_spf <= r2_spf;
         r4_v     <= r3_v;
         r4_sum   <= w_res;
         r4_flags <= w_flg;
      end
   end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: scoreboard bench for fp_add_pipe (single precision
// instance plus a half precision instance sharing clock and reset).
module tb_fp_add_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sub;
   logic        out_valid, out_ready;
   logic [31:0] in_a, in_b, out_sum;
   logic [3:0]  out_flags;

   logic        h_in_valid, h_in_ready, h_in_sub;
   logic        h_out_valid, h_out_ready;
   logic [15:0] h_in_a, h_in_b, h_out_sum;
   logic [3:0]  h_out_flags;

   int          n_vec = 0;
   int          n_bad = 0;
   int          acc_cnt = 0;
   logic [35:0] sbq[$];
   logic [35:0] mon_e;
   logic [31:0] cur_es;
   logic [3:0]  cur_ef;

   always #5 clk = ~clk;

   fp_add_pipe u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_flags(out_flags)
   );

   fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
      .clk(clk), .rst_n(rst_n),
      .in_valid(h_in_valid), .in_ready(h_in_ready),
      .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub),
      .out_valid(h_out_valid), .out_ready(h_out_ready),
      .out_sum(h_out_sum), .out_flags(h_out_flags)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // handshakes are sampled mid-cycle; they take effect on the next edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            sbq.push_back({cur_es, cur_ef});
            acc_cnt++;
         end
         if (out_valid) begin
            if (sbq.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
               mon_e = sbq.pop_front();
               check("sum", 64'(out_sum), 64'(mon_e[35:4]));
               check("flags", 64'(out_flags), 64'(mon_e[3:0]));
            end else begin
               check("held", 64'({out_sum, out_flags}), 64'(sbq[0]));
            end
         end
      end
   end

   // called and returns at 1 time unit after a rising edge
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] es,
                       input logic [3:0] ef);
      int n = 0;
      in_a = a; in_b = b; in_sub = s;
      cur_es = es; cur_ef = ef;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      check("drain", 64'(sbq.size()), 64'd0);
   endtask

   task automatic hsend(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic [3:0] ef);
      int k = 0;
      h_in_a = a; h_in_b = b; h_in_valid = 1'b1;
      @(negedge clk);
      check("h_in_ready", 64'(h_in_ready), 64'd1);
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      while (!h_out_valid && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      check("h_latency", 64'(k), 64'd3);
      check("h_sum", 64'(h_out_sum), 64'(es));
      check("h_flags", 64'(h_out_flags), 64'(ef));
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] es;
      logic [3:0]  ef;
   } vec_t;

   vec_t vecs[$];
   vec_t bps[$];

   initial begin
      vecs = '{
         '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
         '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},
         '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
         '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
         '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001},
         '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000},
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
         '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
         '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},
         '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},
         '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000},
         '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000},
         '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000},
         '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011}
      };
      bps = '{
         '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000},
         '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000},
         '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
         '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000},
         '{32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 4'b0000},
         '{32'h40800000, 32'hBF800000, 1'b0, 32'h40400000, 4'b0000}
      };
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, queue %0d",
               sbq.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
      out_ready = 1'b1;
      cur_es = '0; cur_ef = '0;
      h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0;
      h_in_sub = 1'b0; h_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // latency of a lone transfer into an empty pipe
      send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      k = 0;
      while (!out_valid && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency", 64'(k), 64'd3);
      drain();

      // streaming table
      foreach (vecs[i])
         send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].es, vecs[i].ef);
      drain();

      // back-pressure from an empty pipe
      out_ready = 1'b0;
      acc_cnt = 0;
      fork
         begin
            foreach (bps[i])
               send(bps[i].a, bps[i].b, bps[i].s, bps[i].es, bps[i].ef);
         end
         begin
            repeat (10) @(posedge clk);
            #1;
            check("bp_accepted", 64'(acc_cnt), 64'd4);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_total", 64'(acc_cnt), 64'd6);

      // reset with three items in flight
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
      send(32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 4'b0000);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      sbq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      send(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000);
      drain();
      repeat (5) @(posedge clk);
      #1;

      // half precision instance
      hsend(16'h3C00, 16'h4000, 16'h4200, 4'b0000);
      @(posedge clk); #1;
      hsend(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with valid/ready handshakes on both sides. It is the next-generation replacement for the single-precision combinational adder used in the CNN datapath (convolution accumulate, bias add). Relative to that adder it adds configurable exponent and mantissa widths, an add/subtract mode, round-to-nearest-even, IEEE special-value handling, status flags and a four-stage pipeline with back-pressure.

## Interface
- EXP_W, 8: exponent width; total word width W = 1+EXP_W+MAN_W.
- MAN_W, 23: stored mantissa width, excluding the hidden bit.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  0: A+B; 1: A−B (B sign inverted in stage 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- out_sum  out  W  result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}, aligned with out_sum.

## Operation
- Four register stages (S1–S4). S4 is the output register.
- Global advance enable: en = !(out_valid && !out_ready). in_ready = en, combinational.
- When en = 1, every stage loads from its predecessor, including bubbles. When en = 0, all stages hold.
- S1 (unpack): split the fields and apply in_sub. Classify each operand as zero, normal, inf or NaN. Denormals (exp=0) are flushed to signed zero. Swap so that |A| ≥ |B|, comparing exponent then mantissa. Record the special-case result, if any.
- S2 (align): right-shift the smaller significand by the exponent difference into a width of MAN_W+4 (hidden, mantissa, guard, round, sticky). Sticky is the OR of all bits shifted past round. A shift ≥ MAN_W+3 leaves sticky only.
- S3 (add): effective subtract = sign(A)^sign(B). Add or subtract the significands with one carry bit. The result is always non-negative because of the S1 swap. Result sign = sign of the larger operand.
- S4 (normalise/round/pack):
  - On carry-out: shift right 1 (fold the lost bit into sticky) and increment the exponent.
  - Otherwise: leading-zero count, left shift, and subtract the count from the exponent.
  - Round to nearest even using guard/round/sticky. A mantissa overflow from rounding increments the exponent.
- Special cases (override the arithmetic path; flags as listed):
  - Any NaN input, or inf − inf: canonical quiet NaN (sign 0, exp all ones, mantissa MSB 1, rest 0); invalid=1.
  - inf ± finite: that inf; no flags.
  - Exact zero result from unlike signs: +0. (−0)+(−0) = −0. Zero + x = x exactly.
- Overflow (exp ≥ 2^EXP_W−1 after rounding): ±inf; overflow=1, inexact=1.
- Underflow (exp ≤ 0 after normalisation): flush to signed zero; underflow=1, inexact=1.
- inexact=1 whenever guard|round|sticky ≠ 0 for a finite result.
- Arithmetic width: exponent arithmetic uses EXP_W+2 signed bits so under/overflow is detectable before the final clamp.

## Timing
- Reset (asynchronous assert, synchronous release on clk): all stage valid bits 0, out_valid=0, out_sum=0, out_flags=0, in_ready=1 once reset releases.
- Latency: a transfer on edge t produces out_valid=1 with its result after edge t+3, provided en stayed 1.
- Throughput: one result per cycle while out_ready=1.
- Capacity: 4 in flight. With out_ready held low from empty, exactly 4 transfers are accepted; in_ready falls after the 4th.
- Bubbles are not collapsed. A stall freezes every stage, including empty ones.
- out_sum and out_flags are held stable while out_valid && !out_ready.
- Simultaneous out transfer and new input under stall recovery: both occur on the same edge.
- Reset mid-operation discards every in-flight item; no partial output follows.

## Test plan
- Defaults, streaming: 0x3F800000 + 0x40000000 → 0x40400000, flags 0000, out_valid 3 edges after acceptance.
- Subtract and zero sign: in_sub=1, 0x3F800000 − 0x3F800000 → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000.
- Rounding: 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1. 0x3F800000 + 0x33C00000 → 0x3F800001, inexact=1.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x00400000 + 0x3F800000 → 0x3F800000 (denormal flushed).
- Back-pressure: out_ready=0 while driving 6 back-to-back pairs → 4 accepted, in_ready=0. Then raise out_ready → 6 results in order, no loss or duplication; the output is held stable during the stall.
- Reset mid-stream: assert rst_n=0 with 3 items in flight → out_valid=0 immediately. After release, the first output is from the first post-reset input. Repeat with EXP_W=5, MAN_W=10: 0x3C00 + 0x4000 → 0x4200.
